// File: rtl/data_mem_responder.sv
// data_mem_responder: executor-facing load/store responder over a word RAM.
// Defining DATA_MEM_BOUNDS_CHECK_EN adds an address-range access-fault check.
`ifndef MEM_WIDTH_NONE
`define MEM_WIDTH_NONE 2'd0
`define MEM_WIDTH_BYTE 2'd1
`define MEM_WIDTH_HALF 2'd2
`define MEM_WIDTH_WORD 2'd3
`endif
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`define EXCEP_NONE 4'd0
`define EXCEP_MISALIGNED_LOAD 4'd4
`define EXCEP_LOAD_FAULT 4'd5
`define EXCEP_MISALIGNED_STORE 4'd6
`define EXCEP_STORE_FAULT 4'd7
`endif

module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                      clk_In,
  input  logic                      rst_In,
  input  logic                      memAccess_In,
  input  logic [31:0]               memAddr_In,
  input  logic [31:0]               memData_In,
  input  logic [1:0]                memDataWidth_In,
  input  logic                      memIsRead_In,
  output logic                      memAccessOK_Out,
  output logic [31:0]               memData_Out,
  output logic [`EXCEPTION_LEN-1:0] memException_Out
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] addr_q, data_q;
  logic [1:0]  width_q;
  logic        read_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] addr, data, off, word, rdata;
  logic [1:0]  width, lane;
  logic        rd, skip, fire, we;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [`EXCEPTION_LEN-1:0] exc;
  logic        ok_nxt;
  logic [31:0] data_nxt;
  logic [`EXCEPTION_LEN-1:0] exc_nxt;
  logic        unused_off;

  // In IDLE the live request is decoded so a zero-wait access resolves on its accept edge.
  always_comb begin
    addr  = addr_q;
    data  = data_q;
    width = width_q;
    rd    = read_q;
    if (state == IDLE) begin
      addr  = memAddr_In;
      data  = memData_In;
      width = memDataWidth_In;
      rd    = memIsRead_In;
    end
  end

  assign off  = addr - BASE_ADDR;
  assign idx  = off[AW+1:2];
  assign lane = off[1:0];
  assign word = mem[idx];
  assign unused_off = ^off;

  always_comb begin
    skip = 1'b0;
    exc  = `EXCEP_NONE;
    if (width == `MEM_WIDTH_NONE) begin
      skip = 1'b1;
    end else if ((width == `MEM_WIDTH_HALF && lane[0]) ||
                 (width == `MEM_WIDTH_WORD && lane != 2'd0)) begin
      skip = 1'b1;
      exc  = rd ? `EXCEP_MISALIGNED_LOAD : `EXCEP_MISALIGNED_STORE;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    end else if ({1'b0, off} >= SPAN) begin
      skip = 1'b1;
      exc  = rd ? `EXCEP_LOAD_FAULT : `EXCEP_STORE_FAULT;
`endif
    end
  end

  always_ff @(posedge clk_In or posedge rst_In) begin
    if (rst_In) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      addr_q           <= 32'd0;
      data_q           <= 32'd0;
      width_q          <= `MEM_WIDTH_NONE;
      read_q           <= 1'b0;
      memAccessOK_Out  <= 1'b0;
      memData_Out      <= 32'd0;
      memException_Out <= `EXCEP_NONE;
    end else begin
      state            <= state_nxt;
      memAccessOK_Out  <= ok_nxt;
      memData_Out      <= data_nxt;
      memException_Out <= exc_nxt;
      if (state == IDLE && memAccess_In) begin
        addr_q  <= memAddr_In;
        data_q  <= memData_In;
        width_q <= memDataWidth_In;
        read_q  <= memIsRead_In;
        cnt     <= 4'(WAIT_CYCLES - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (memAccess_In)
          state_nxt = (skip || WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:
        if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdata = word;
    unique case (width)
      `MEM_WIDTH_BYTE: rdata = {24'd0, word[8*lane +: 8]};
      `MEM_WIDTH_HALF: rdata = {16'd0, word[16*lane[1] +: 16]};
      default:         rdata = word;
    endcase
  end

  assign fire = (state_nxt == RESP) && (state != RESP);

  always_comb begin
    ok_nxt   = fire;
    data_nxt = (fire && rd && !skip) ? rdata : 32'd0;
    exc_nxt  = fire ? exc : `EXCEP_NONE;
  end

  always_comb begin
    be = 4'b1111;
    wd = data;
    unique case (width)
      `MEM_WIDTH_BYTE: begin
        be = 4'b0001 << lane;
        wd = {4{data[7:0]}};
      end
      `MEM_WIDTH_HALF: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{data[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = data;
      end
    endcase
  end

  // Writes land only on the edge entering RESP, so a reset in WAIT drops the store.
  assign we = fire && !rd && !skip && !rst_In;

  always_ff @(posedge clk_In) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: random and directed load/store checks
// against a byte-array reference model of the data RAM.
`ifndef MEM_WIDTH_NONE
`define MEM_WIDTH_NONE 2'd0
`define MEM_WIDTH_BYTE 2'd1
`define MEM_WIDTH_HALF 2'd2
`define MEM_WIDTH_WORD 2'd3
`endif
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`define EXCEP_NONE 4'd0
`define EXCEP_MISALIGNED_LOAD 4'd4
`define EXCEP_LOAD_FAULT 4'd5
`define EXCEP_MISALIGNED_STORE 4'd6
`define EXCEP_STORE_FAULT 4'd7
`endif

module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int W = 1;
  localparam logic [31:0] BASE = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic access = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] data = 32'd0;
  logic [1:0] width = 2'd0;
  logic is_read = 1'b0;
  logic ok;
  logic [31:0] rdata;
  logic [`EXCEPTION_LEN-1:0] exc;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem_b [DEPTH*4];

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(W),
    .BASE_ADDR(BASE)
  ) dut (
    .clk_In(clk),
    .rst_In(rst),
    .memAccess_In(access),
    .memAddr_In(addr),
    .memData_In(data),
    .memDataWidth_In(width),
    .memIsRead_In(is_read),
    .memAccessOK_Out(ok),
    .memData_Out(rdata),
    .memException_Out(exc)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outcome from the access rules; mutates the byte array on stores.
  task automatic model(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] w, input logic rd,
                       output logic [31:0] ed, output logic [31:0] ee,
                       output int el);
    int n;
    int b;
    logic [31:0] o;
    ed = 32'd0;
    ee = 32'(`EXCEP_NONE);
    el = 0;
    n = (w == `MEM_WIDTH_BYTE) ? 1 : (w == `MEM_WIDTH_HALF) ? 2 :
        (w == `MEM_WIDTH_WORD) ? 4 : 0;
    o = a - BASE;
    if (n == 0) return;
    if (a % n != 0) begin
      ee = rd ? 32'(`EXCEP_MISALIGNED_LOAD) : 32'(`EXCEP_MISALIGNED_STORE);
      return;
    end
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    if (o >= DEPTH * 4) begin
      ee = rd ? 32'(`EXCEP_LOAD_FAULT) : 32'(`EXCEP_STORE_FAULT);
      return;
    end
`endif
    el = W;
    b = int'(o % (DEPTH * 4));
    for (int k = 0; k < n; k++) begin
      if (rd) ed = ed | (32'(mem_b[b+k]) << (8 * k));
      else mem_b[b+k] = d[8*k +: 8];
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] w, input logic rd,
                        output logic [31:0] got_d, output logic [31:0] got_e);
    logic [31:0] ed, ee;
    int el;
    int lat;
    bit seen;
    model(a, d, w, rd, ed, ee, el);
    @(negedge clk);
    access = 1'b1; addr = a; data = d; width = w; is_read = rd;
    lat = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (ok) begin
        seen = 1'b1;
        break;
      end
      lat++;
      addr = $urandom; data = $urandom;
      width = 2'($urandom); is_read = 1'($urandom); access = 1'($urandom);
    end
    access = 1'b0;
    chk("ok_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(el));
    chk("rdata", rdata, ed);
    chk("exc", 32'(exc), ee);
    got_d = rdata;
    got_e = 32'(exc);
    @(posedge clk); #1;
    chk("ok_one_cycle", 32'(ok), 32'd0);
  endtask

  logic [31:0] gd, ge, ra, ea, eb, ee0;
  int el0, pulses, t1, t2;

  initial begin
    for (int i = 0; i < DEPTH * 4; i++) mem_b[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ok", 32'(ok), 32'd0);
    chk("rst_data", rdata, 32'd0);
    chk("rst_exc", 32'(exc), 32'(`EXCEP_NONE));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++)
      do_req(32'(i * 4), (i == 4) ? 32'd0 : $urandom, `MEM_WIDTH_WORD, 1'b0, gd, ge);

    // Reset while a store sits in WAIT.
    @(negedge clk);
    access = 1'b1; addr = 32'h10; data = 32'hDEADBEEF;
    width = `MEM_WIDTH_WORD; is_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    access = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ok) pulses++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ok) pulses++;
    end
    chk("rst_no_ok", 32'(pulses), 32'd0);
    do_req(32'h10, 32'd0, `MEM_WIDTH_WORD, 1'b1, gd, ge);
    chk("rst_no_write", 32'(gd == 32'hDEADBEEF), 32'd0);

    do_req(32'h20, 32'h12345678, `MEM_WIDTH_WORD, 1'b0, gd, ge);
    do_req(32'h20, 32'd0, `MEM_WIDTH_WORD, 1'b1, gd, ge);
    chk("ld_word", gd, 32'h12345678);
    do_req(32'h21, 32'hFFFFFFAB, `MEM_WIDTH_BYTE, 1'b0, gd, ge);
    do_req(32'h20, 32'd0, `MEM_WIDTH_WORD, 1'b1, gd, ge);
    chk("ld_after_sb", gd, 32'h1234AB78);
    do_req(32'h22, 32'd0, `MEM_WIDTH_HALF, 1'b1, gd, ge);
    chk("ld_half", gd, 32'h00001234);
    do_req(32'h23, 32'd0, `MEM_WIDTH_BYTE, 1'b1, gd, ge);
    chk("ld_byte", gd, 32'h00000012);

    do_req(32'h21, 32'd0, `MEM_WIDTH_HALF, 1'b1, gd, ge);
    chk("mis_ld", ge, 32'(`EXCEP_MISALIGNED_LOAD));
    do_req(32'h22, 32'h55555555, `MEM_WIDTH_WORD, 1'b0, gd, ge);
    chk("mis_st", ge, 32'(`EXCEP_MISALIGNED_STORE));
    do_req(32'h20, 32'd0, `MEM_WIDTH_WORD, 1'b1, gd, ge);
    chk("mis_st_nowr", gd, 32'h1234AB78);
    do_req(32'h24, 32'h77777777, `MEM_WIDTH_NONE, 1'b0, gd, ge);
    chk("none_exc", ge, 32'(`EXCEP_NONE));

`ifdef DATA_MEM_BOUNDS_CHECK_EN
    do_req(32'h1000, 32'd0, `MEM_WIDTH_WORD, 1'b1, gd, ge);
    chk("oob_ld", ge, 32'(`EXCEP_LOAD_FAULT));
`else
    do_req(32'h1000, 32'hCAFEF00D, `MEM_WIDTH_WORD, 1'b0, gd, ge);
    do_req(32'h0, 32'd0, `MEM_WIDTH_WORD, 1'b1, gd, ge);
    chk("alias_ld", gd, 32'hCAFEF00D);
`endif

    // Back-to-back loads with the request held high through RESP.
    model(32'h20, 32'd0, `MEM_WIDTH_WORD, 1'b1, ea, ee0, el0);
    model(32'h40, 32'd0, `MEM_WIDTH_WORD, 1'b1, eb, ee0, el0);
    @(negedge clk);
    access = 1'b1; addr = 32'h20; width = `MEM_WIDTH_WORD; is_read = 1'b1;
    pulses = 0; t1 = -1; t2 = -1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (ok) begin
        pulses++;
        if (t1 < 0) begin
          t1 = c;
          ra = rdata;
          addr = 32'h40;
        end else if (t2 < 0) begin
          t2 = c;
          chk("b2b_second", rdata, eb);
          access = 1'b0;
        end
      end
    end
    access = 1'b0;
    chk("b2b_first", ra, ea);
    chk("b2b_gap", 32'(t2 - t1), 32'(W + 2));
    chk("b2b_pulses", 32'(pulses), 32'd2);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom % 128) | (($urandom % 4 == 0) ? 32'h1000 : 32'h0);
      do_req(a, $urandom, 2'($urandom), 1'($urandom), gd, ge);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
